// File: rtl/seg_display_mux.sv
// Two-digit common-anode seven-segment scanner with per-frame shadow latching and dead-time gaps.
// Optional macro LEADING_ZERO_BLANK_EN blanks the tens digit whenever the latched tens value is zero.
module seg_display_mux #(
    parameter int DIGIT_W     = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYC    = 500
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DIGIT_W-1:0] tens,
    input  logic [DIGIT_W-1:0] ones,
    output logic [6:0]         seg,
    output logic [1:0]         an,
    output logic               frame_tick
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    typedef enum logic [1:0] {
        DEAD_ONES = 2'd0,
        ON_ONES   = 2'd1,
        DEAD_TENS = 2'd2,
        ON_TENS   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      w_cntNext;
    logic [DIGIT_W-1:0] r_shTens;
    logic [DIGIT_W-1:0] r_shOnes;
    logic [DIGIT_W-1:0] w_shTensNext;
    logic [DIGIT_W-1:0] w_shOnesNext;
    logic [6:0]         r_seg;
    logic [6:0]         w_segNext;
    logic [1:0]         r_an;
    logic [1:0]         w_anNext;
    logic               r_frameTick;
    logic               w_frameTickNext;
    logic               w_wrap;
    logic               w_isTensSlot;
    logic               w_tensSlotNext;
    logic               w_inDead;

    function automatic logic [6:0] decodeDigit(input logic [DIGIT_W-1:0] d);
        logic [6:0] s;
        case (d)
            DIGIT_W'(0): s = 7'b1000000;
            DIGIT_W'(1): s = 7'b1111001;
            DIGIT_W'(2): s = 7'b0100100;
            DIGIT_W'(3): s = 7'b0110000;
            DIGIT_W'(4): s = 7'b0011001;
            DIGIT_W'(5): s = 7'b0010010;
            DIGIT_W'(6): s = 7'b0000010;
            DIGIT_W'(7): s = 7'b1111000;
            DIGIT_W'(8): s = 7'b0000000;
            DIGIT_W'(9): s = 7'b0010000;
            default:     s = SEG_DASH;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= DEAD_ONES;
            r_cnt       <= '0;
            r_shTens    <= '0;
            r_shOnes    <= '0;
            r_seg       <= SEG_OFF;
            r_an        <= 2'b11;
            r_frameTick <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_cnt       <= w_cntNext;
            r_shTens    <= w_shTensNext;
            r_shOnes    <= w_shOnesNext;
            r_seg       <= w_segNext;
            r_an        <= w_anNext;
            r_frameTick <= w_frameTickNext;
        end
    end

    // Outputs are computed from the state being entered so they change on the same edge as it.
    always_comb begin
        w_stateNext     = r_state;
        w_shTensNext    = r_shTens;
        w_shOnesNext    = r_shOnes;
        w_segNext       = SEG_OFF;
        w_anNext        = 2'b11;
        w_frameTickNext = 1'b0;

        w_wrap         = (r_cnt == CNT_MAX);
        w_cntNext      = w_wrap ? '0 : r_cnt + 1'b1;
        w_isTensSlot   = (r_state == DEAD_TENS) || (r_state == ON_TENS);
        w_tensSlotNext = w_wrap ? ~w_isTensSlot : w_isTensSlot;
        w_inDead       = (int'(w_cntNext) < DEAD_CYC);

        if (w_wrap && w_isTensSlot) begin
            w_shTensNext    = tens;
            w_shOnesNext    = ones;
            w_frameTickNext = 1'b1;
        end

        if (w_tensSlotNext) begin
            w_stateNext = w_inDead ? DEAD_TENS : ON_TENS;
        end else begin
            w_stateNext = w_inDead ? DEAD_ONES : ON_ONES;
        end

        case (w_stateNext)
            ON_ONES: begin
                w_segNext = decodeDigit(w_shOnesNext);
                w_anNext  = 2'b10;
            end
            ON_TENS: begin
`ifdef LEADING_ZERO_BLANK_EN
                if (w_shTensNext != '0) begin
                    w_segNext = decodeDigit(w_shTensNext);
                    w_anNext  = 2'b01;
                end
`else
                w_segNext = decodeDigit(w_shTensNext);
                w_anNext  = 2'b01;
`endif
            end
            default: begin
                w_segNext = SEG_OFF;
                w_anNext  = 2'b11;
            end
        endcase
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_tick = r_frameTick;

endmodule
